// File: rtl/reg_file_2r1w_if.sv
// Port bundle for reg_file_2r1w: one write port and two registered read ports.
interface reg_file_2r1w_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int SEL_W    = $clog2(NUM_REGS)
);
  logic             we;
  logic [SEL_W-1:0] wa;
  logic [WIDTH-1:0] wd;

  logic             re_a;
  logic [SEL_W-1:0] ra_a;
  logic [WIDTH-1:0] rd_a;
  logic             valid_a;

  logic             re_b;
  logic [SEL_W-1:0] ra_b;
  logic [WIDTH-1:0] rd_b;
  logic             valid_b;

  modport master (
    output we, wa, wd,
    output re_a, ra_a, re_b, ra_b,
    input  rd_a, valid_a, rd_b, valid_b
  );

  modport slave (
    input  we, wa, wd,
    input  re_a, ra_a, re_b, ra_b,
    output rd_a, valid_a, rd_b, valid_b
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file with one synchronous write port and two registered read ports.
// Optional same-edge write-to-read forwarding is enabled by defining RF_WRITE_BYPASS_EN.
module reg_file_2r1w #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input logic            clk,
  input logic            reset,
  reg_file_2r1w_if.slave bus
);

  logic [WIDTH-1:0] mem [NUM_REGS];

  logic [WIDTH-1:0] rd_a_q;
  logic [WIDTH-1:0] rd_b_q;
  logic             valid_a_q;
  logic             valid_b_q;

  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             wr_ok;

  function automatic logic addr_in_range(input logic [SEL_W-1:0] addr);
    return int'(addr) < NUM_REGS;
  endfunction

  // Register 0 is hard zero and out-of-range addresses have no storage.
  assign wr_ok = bus.we && (bus.wa != '0) && addr_in_range(bus.wa);

  always_comb begin
    next_a = '0;
    if ((bus.ra_a != '0) && addr_in_range(bus.ra_a)) begin
      next_a = mem[bus.ra_a];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_ok && (bus.wa == bus.ra_a)) begin
        next_a = bus.wd;
      end
`endif
    end
  end

  always_comb begin
    next_b = '0;
    if ((bus.ra_b != '0) && addr_in_range(bus.ra_b)) begin
      next_b = mem[bus.ra_b];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_ok && (bus.wa == bus.ra_b)) begin
        next_b = bus.wd;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
    end else if (wr_ok) begin
      mem[bus.wa] <= bus.wd;
    end
  end

  // Read data holds across idle cycles; valid marks only the edge that loaded it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      valid_a_q <= bus.re_a;
      valid_b_q <= bus.re_b;
      if (bus.re_a) begin
        rd_a_q <= next_a;
      end
      if (bus.re_b) begin
        rd_b_q <= next_b;
      end
    end
  end

  assign bus.rd_a    = rd_a_q;
  assign bus.rd_b    = rd_b_q;
  assign bus.valid_a = valid_a_q;
  assign bus.valid_b = valid_b_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Testbench for reg_file_2r1w: a 32-entry and a 24-entry instance driven in lockstep
// against a reference model, with expected results queued per step.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_file_2r1w_if #(.WIDTH(32), .NUM_REGS(32)) bus32 ();
  reg_file_2r1w_if #(.WIDTH(32), .NUM_REGS(24)) bus24 ();

  reg_file_2r1w #(.WIDTH(32), .NUM_REGS(32)) dut32 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus32)
  );

  reg_file_2r1w #(.WIDTH(32), .NUM_REGS(24)) dut24 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus24)
  );

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [31:0] a24;
    logic [31:0] b24;
    logic        va;
    logic        vb;
  } exp_t;

  exp_t        scoreboard[$];
  logic [31:0] m32 [32];
  logic [31:0] m24 [32];
  logic [31:0] prevA32, prevB32, prevA24, prevB24;
  int          passCount  = 0;
  int          checkCount = 0;

  function automatic logic [31:0] expRead(input int n, input logic [31:0] word,
                                          input logic re, input logic [4:0] ra,
                                          input logic [31:0] prev, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (!re) return prev;
    if (ra == 5'd0 || int'(ra) >= n) return 32'd0;
    if (BYPASS && we && (wa == ra)) return wd;
    return word;
  endfunction

  task automatic cmp(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, expv);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkCount++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = scoreboard.pop_front();
    cmp(e.tag, "rd_a32",    bus32.rd_a,              e.a32);
    cmp(e.tag, "rd_b32",    bus32.rd_b,              e.b32);
    cmp(e.tag, "valid_a32", {31'd0, bus32.valid_a},  {31'd0, e.va});
    cmp(e.tag, "valid_b32", {31'd0, bus32.valid_b},  {31'd0, e.vb});
    cmp(e.tag, "rd_a24",    bus24.rd_a,              e.a24);
    cmp(e.tag, "rd_b24",    bus24.rd_b,              e.b24);
    cmp(e.tag, "valid_a24", {31'd0, bus24.valid_a},  {31'd0, e.va});
    cmp(e.tag, "valid_b24", {31'd0, bus24.valid_b},  {31'd0, e.vb});
  endtask

  task automatic applyStimulus(input string tag, input logic rst,
                               input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic reA, input logic [4:0] raA,
                               input logic reB, input logic [4:0] raB);
    exp_t e;
    reset      = rst;
    bus32.we   = w;   bus24.we   = w;
    bus32.wa   = wa;  bus24.wa   = wa;
    bus32.wd   = wd;  bus24.wd   = wd;
    bus32.re_a = reA; bus24.re_a = reA;
    bus32.ra_a = raA; bus24.ra_a = raA;
    bus32.re_b = reB; bus24.re_b = reB;
    bus32.ra_b = raB; bus24.ra_b = raB;

    e.tag = tag;
    if (rst) begin
      e.a32 = 32'd0; e.b32 = 32'd0; e.a24 = 32'd0; e.b24 = 32'd0;
      e.va  = 1'b0;  e.vb  = 1'b0;
    end else begin
      e.a32 = expRead(32, m32[raA], reA, raA, prevA32, w, wa, wd);
      e.b32 = expRead(32, m32[raB], reB, raB, prevB32, w, wa, wd);
      e.a24 = expRead(24, m24[raA], reA, raA, prevA24, w, wa, wd);
      e.b24 = expRead(24, m24[raB], reB, raB, prevB24, w, wa, wd);
      e.va  = reA;
      e.vb  = reB;
    end
    prevA32 = e.a32; prevB32 = e.b32; prevA24 = e.a24; prevB24 = e.b24;
    scoreboard.push_back(e);

    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m32[i] = 32'd0;
        m24[i] = 32'd0;
      end
    end else if (w && wa != 5'd0) begin
      m32[wa] = wd;
      if (int'(wa) < 24) m24[wa] = wd;
    end

    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    prevA32 = 32'd0; prevB32 = 32'd0; prevA24 = 32'd0; prevB24 = 32'd0;
    for (int i = 0; i < 32; i++) begin
      m32[i] = 32'd0;
      m24[i] = 32'd0;
    end

    applyStimulus("reset0", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus("reset1", 1'b1, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 1'b1, 5'd3);

    for (int i = 0; i < 32; i++)
      applyStimulus("rd_zero", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(i));
    applyStimulus("idle", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);

    for (int i = 0; i < 32; i++)
      applyStimulus("wr_n", 1'b0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++)
      applyStimulus("sweep", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));

    applyStimulus("set_r5",   1'b0, 1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus("same_edge", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd6);
    applyStimulus("after_wr", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);

    applyStimulus("rst_wr",  1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd7, 1'b1, 5'd7);
    applyStimulus("read_r7", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);

    applyStimulus("w23",   1'b0, 1'b1, 5'd23, 32'h17, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus("w30",   1'b0, 1'b1, 5'd30, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus("oor_rd", 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 1'b1, 5'd23);

    applyStimulus("w9",     1'b0, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 1'b0, 5'd0);
    applyStimulus("load9",  1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0);
    applyStimulus("hold_w", 1'b0, 1'b1, 5'd9, 32'hFF, 1'b0, 5'd9, 1'b0, 5'd0);
    applyStimulus("hold",   1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd9, 1'b0, 5'd0);
    applyStimulus("rd9",    1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);

    applyStimulus("w0_rd0", 1'b0, 1'b1, 5'd0, 32'hCAFE, 1'b1, 5'd0, 1'b1, 5'd0);
    applyStimulus("rd0",    1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);

    for (int i = 0; i < 60; i++)
      applyStimulus("random", 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    32'($urandom), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file with one synchronous write port and two registered read ports. Each read port is a NUM_REGS-to-1 selector in front of an output register. It replaces the fixed 32-input, 32-bit combinational selector in the datapath. The block sits between instruction decode (register addresses) and the ALU operand inputs.

## Interface
Parameters:
- WIDTH, 32, data width of every register and port.
- NUM_REGS, 32, number of registers; legal range 2..64.
- SEL_W, $clog2(NUM_REGS), width of every address port (derived; do not override).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- we  input  1  write enable.
- wa  input  SEL_W  write address.
- wd  input  WIDTH  write data.
- re_a  input  1  read enable, port A.
- ra_a  input  SEL_W  read address, port A.
- rd_a  output  WIDTH  registered read data, port A.
- re_b  input  1  read enable, port B.
- ra_b  input  SEL_W  read address, port B.
- rd_b  output  WIDTH  registered read data, port B.
- valid_a, valid_b  output  1  rd_x was updated by a read on the previous edge.

## Operation
- Storage: NUM_REGS words of WIDTH bits.
  - Register 0 always reads 0; writes to address 0 are discarded.
- Write: on an edge with we=1 and reset=0, mem[wa] <= wd.
  - Writes are ignored when wa=0 or wa>=NUM_REGS.
- Read: on an edge with re_x=1 and reset=0:
  - rd_x <= mem[ra_x], or 0 if ra_x>=NUM_REGS.
  - valid_x <= 1.
- Idle read: on an edge with re_x=0, rd_x holds its value and valid_x <= 0.
- Independence: ports A and B operate independently. Both ports may read the same address in the same cycle, and both return the same data.
- Reset: on an edge with reset=1:
  - all mem words, rd_a, rd_b, valid_a and valid_b clear to 0;
  - we and re_x are ignored on that edge.
- Reset asserted mid-stream discards any pending write on that edge. The first read after deassertion returns 0 for every address.
- No state machine. State is the memory array plus two output registers and two valid flags.

## Timing
- Read latency: 1 cycle. An address presented before edge N appears on rd_x after edge N, and stays stable until the next enabled read or reset.
- Write latency: 1 cycle. Data written at edge N is visible to a read sampled at edge N+1 in every configuration.
- Read and write to the same nonzero address at the same edge: resolved by the bypass option (see Configuration).
- Reset values: rd_a=0, rd_b=0, valid_a=0, valid_b=0, every mem word=0.
- There are no combinational paths from any input to any output.

## Configuration
- Macro: RF_WRITE_BYPASS_EN.
- Defined: a read sampled on the same edge as a write returns wd when all of the following hold at that edge:
  - re_x=1 and we=1;
  - ra_x==wa;
  - wa!=0 and wa<NUM_REGS.
- Undefined: in that same case the read returns the old mem[ra_x], i.e. read-before-write. The new value is visible from the next read onward.
- The bypass never overrides address 0 or out-of-range addresses; those always read 0.

## Test plan
- Reset, then read every address on both ports: rd_a=rd_b=0 for all 32 addresses. valid_x=1 on the cycle after each read and 0 when re_x=0.
- Write Rn=n for n=0..31, then sweep ra_a=0..31 and ra_b=31..0.
  - rd_a=n and rd_b=31-n, each one cycle after its address.
  - R0 reads 0.
- Same-edge write and read: R5=0x5, then we=1, wa=5, wd=0xDEADBEEF, re_a=1, ra_a=5.
  - RF_WRITE_BYPASS_EN defined: rd_a=0xDEADBEEF.
  - Undefined: rd_a=0x5.
  - In both configurations the next read of R5 returns 0xDEADBEEF.
- Assert reset for one cycle with we=1, wa=7, wd=0x77. The next read of R7 returns 0, and valid_a=valid_b=0 after the reset edge.
- With NUM_REGS=24: write wa=30, wd=0x1234, then read ra_a=30 and ra_b=23 (R23 previously =0x17). Required: rd_a=0, rd_b=0x17.
- Hold test: load rd_a=0x9 with R9=0x9, set re_a=0 and write R9=0xFF. rd_a stays 0x9 and valid_a=0 until the next enabled read.
